debounce_multi: RTL and testbench
=================================

// Module: debounce_multi
// PURPOSE
//  Parametrised N-channel switch/button debouncer for board inputs (keys, DIP switches).
//  - Each channel has its own 2-flop synchroniser and a stability counter.
//  - Produces a level-clean output per channel, plus one-cycle rise/fall event pulses.
//  - Sits between raw board pins and user logic; all outputs are in the clk domain.
// PARAMETERS
//  N_CH          4        number of independent channels (>=1)
//  STABLE_CYCLES 2097152  consecutive stable synced cycles before clean_out updates (>=2)
//  RESET_VAL     1'b0     reset value of every clean_out bit
//  CNT_W         $clog2(STABLE_CYCLES)  stability counter width (derived, do not override)
// PORTS
//  clk        in   1     system clock (50MHz)
//  rst        in   1     asynchronous, active-high reset
//  bouncy_in  in   N_CH  raw asynchronous inputs
//  clean_out  out  N_CH  debounced levels
//  rise_pulse out  N_CH  1-cycle pulse when clean_out[i] goes 0->1
//  fall_pulse out  N_CH  1-cycle pulse when clean_out[i] goes 1->0
//  any_event  out  1     OR of all rise_pulse|fall_pulse bits (registered with them)
// BEHAVIOUR
//  Reset (async assert, sync-safe release):
//  - clean_out=RESET_VAL per bit; rise/fall/any_event=0; counters=0.
//  - Synchroniser flops and prev-sample flops are also reset to RESET_VAL.
//  Per channel i, every posedge clk (s=synchroniser output, p=prev s, c=counter):
//  - p<=s.
//  - s!=p: c<=0 (bounce detected, restart).
//  - else if c!=STABLE_CYCLES-1: c<=c+1.
//  - else (stable STABLE_CYCLES cycles): clean_out[i]<=s; c holds at max.
//  Event pulses:
//  - rise/fall asserted on the same edge clean_out changes, high exactly 1 cycle.
//  - No pulse if clean_out is rewritten with its current value.
//  Latency:
//  - bouncy_in changes and is held before edge 1 -> clean_out and pulse change at edge STABLE_CYCLES+3.
//  - Any toggle of s restarts the count; a pulse shorter than STABLE_CYCLES synced cycles never reaches clean_out.
//  Channels are fully independent; simultaneous events on several channels all pulse in the same cycle.
//  Counter never wraps: it saturates at STABLE_CYCLES-1 while the input stays stable.
//  Reset mid-count discards all progress; the post-reset count starts from 0.
// CONFIGURATION
//  DEBOUNCE_BOUNCE_COUNT_EN defined:
//   - Extra ports: bcnt_clr in 1, bcnt_sel in $clog2(N_CH) (min 1), bcnt_out out 8.
//   - Per-channel 8-bit bounce counter: +1 on each s!=p detection, saturates at 255.
//   - Counter cleared by rst or by bcnt_clr; bcnt_clr wins over a same-cycle increment.
//   - bcnt_out = counter[bcnt_sel], combinational; 0 if bcnt_sel>=N_CH.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING (N_CH=4, STABLE_CYCLES=4 unless noted)
//  1 Reset with RESET_VAL=0 -> all outputs 0; with RESET_VAL=1 -> clean_out=4'hF, no pulses after release.
//  2 bouncy_in[0] 0->1 held before edge 1 -> clean_out[0]=1 and rise_pulse[0]=1 at edge 7; any_event=1 for 1 cycle.
//  3 bouncy_in[1] toggles every 2 cycles for 20 cycles, then holds 1 -> no change until 7 edges after last toggle, then a single rise.
//  4 Glitch of 3 cycles on ch2 -> clean_out[2] unchanged, no pulses.
//  5 Ch0 rises and ch3 falls on the same edge -> rise_pulse=4'b0001 and fall_pulse=4'b1000 in the same cycle.
//    rst asserted at count 2 -> clean_out reverts to RESET_VAL, no stale update after release.
//  6 [DEBOUNCE_BOUNCE_COUNT_EN] 300 toggles on ch1, bcnt_sel=1 -> bcnt_out=255.
//    bcnt_clr together with a toggle -> bcnt_out=0; bcnt_sel=2 -> 0.

Source files
------------

// File: rtl/debounce_multi.sv
// N-channel switch/button debouncer.
// Each channel: 2-flop synchroniser, previous-sample flop and a saturating stability
// counter. clean_out follows the synchronised input only after it has held the same
// value for STABLE_CYCLES consecutive cycles; rise/fall pulses mark each change.
// Optional feature (macro DEBOUNCE_BOUNCE_COUNT_EN): per-channel 8-bit saturating bounce
// counters, readable through bcnt_sel/bcnt_out and cleared by bcnt_clr.
module debounce_multi #(
    parameter int unsigned N_CH          = 4,
    parameter int unsigned STABLE_CYCLES = 2097152,
    parameter logic        RESET_VAL     = 1'b0,
    localparam int unsigned CNT_W        = $clog2(STABLE_CYCLES),
    localparam int unsigned SEL_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  bouncy_in,
    output logic [N_CH-1:0]  clean_out,
    output logic [N_CH-1:0]  rise_pulse,
    output logic [N_CH-1:0]  fall_pulse,
    output logic             any_event
`ifdef DEBOUNCE_BOUNCE_COUNT_EN
    ,
    input  logic             bcnt_clr,
    input  logic [SEL_W-1:0] bcnt_sel,
    output logic [7:0]       bcnt_out
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [N_CH-1:0]  sync1_q;
    logic [N_CH-1:0]  sync_q;
    logic [N_CH-1:0]  prev_q;
    logic [N_CH-1:0]  clean_q, clean_d;
    logic [N_CH-1:0]  rise_q, rise_d;
    logic [N_CH-1:0]  fall_q, fall_d;
    logic             any_q;
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];

    // Synchroniser chain and previous-sample register; reset to the idle level so a
    // release with the inputs at RESET_VAL produces no spurious activity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= {N_CH{RESET_VAL}};
            sync_q  <= {N_CH{RESET_VAL}};
            prev_q  <= {N_CH{RESET_VAL}};
        end else begin
            sync1_q <= bouncy_in;
            sync_q  <= sync1_q;
            prev_q  <= sync_q;
        end
    end

    // Per-channel stability counting, level update and edge detection.
    always_comb begin
        clean_d = clean_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync_q[i] != prev_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] != CNT_MAX) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else begin
                // Counter holds at max; rewriting the same level must not pulse.
                clean_d[i] = sync_q[i];
                rise_d[i]  = sync_q[i] & ~clean_q[i];
                fall_d[i]  = ~sync_q[i] & clean_q[i];
            end
        end
    end

    // Debounced level, counters and event pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clean_q <= {N_CH{RESET_VAL}};
            rise_q  <= '0;
            fall_q  <= '0;
            any_q   <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            any_q   <= |(rise_d | fall_d);
            cnt_q   <= cnt_d;
        end
    end

    assign clean_out  = clean_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign any_event  = any_q;

`ifdef DEBOUNCE_BOUNCE_COUNT_EN
    logic [7:0] bcnt_q [N_CH];
    logic [7:0] bcnt_d [N_CH];

    // Bounce counters: count synchronised transitions, saturate, clear has priority.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            bcnt_d[i] = bcnt_q[i];
            if (bcnt_clr) begin
                bcnt_d[i] = '0;
            end else if ((sync_q[i] != prev_q[i]) && (bcnt_q[i] != 8'hFF)) begin
                bcnt_d[i] = bcnt_q[i] + 8'd1;
            end
        end
    end

    // Bounce counter state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                bcnt_q[i] <= '0;
            end
        end else begin
            bcnt_q <= bcnt_d;
        end
    end

    // Read mux; a selector with no matching channel reads as zero.
    always_comb begin
        bcnt_out = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (bcnt_sel == SEL_W'(i)) begin
                bcnt_out = bcnt_q[i];
            end
        end
    end
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi (N_CH=4, STABLE_CYCLES=4).
// dut0 resets to 0, dut1 resets to 1. Inputs change 1 time unit after a rising edge,
// outputs are sampled 1 time unit after each rising edge.
module tb_debounce_multi;

    logic       clk;
    logic       rst;
    logic [3:0] bin0;
    logic [3:0] bin1;
    logic [3:0] clean0, rise0, fall0;
    logic [3:0] clean1, rise1, fall1;
    logic       any0, any1;
    int         checks;
    int         errors;

`ifdef DEBOUNCE_BOUNCE_COUNT_EN
    logic       bcnt_clr;
    logic [1:0] bcnt_sel;
    logic [7:0] bcnt_out0;
    logic [7:0] bcnt_out1;
`endif

    debounce_multi #(
        .N_CH          (4),
        .STABLE_CYCLES (4),
        .RESET_VAL     (1'b0)
    ) dut0 (
        .clk        (clk),
        .rst        (rst),
        .bouncy_in  (bin0),
        .clean_out  (clean0),
        .rise_pulse (rise0),
        .fall_pulse (fall0),
        .any_event  (any0)
`ifdef DEBOUNCE_BOUNCE_COUNT_EN
        ,
        .bcnt_clr   (bcnt_clr),
        .bcnt_sel   (bcnt_sel),
        .bcnt_out   (bcnt_out0)
`endif
    );

    debounce_multi #(
        .N_CH          (4),
        .STABLE_CYCLES (4),
        .RESET_VAL     (1'b1)
    ) dut1 (
        .clk        (clk),
        .rst        (rst),
        .bouncy_in  (bin1),
        .clean_out  (clean1),
        .rise_pulse (rise1),
        .fall_pulse (fall1),
        .any_event  (any1)
`ifdef DEBOUNCE_BOUNCE_COUNT_EN
        ,
        .bcnt_clr   (1'b0),
        .bcnt_sel   (2'd0),
        .bcnt_out   (bcnt_out1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        bin0   = 4'h0;
        bin1   = 4'hF;
`ifdef DEBOUNCE_BOUNCE_COUNT_EN
        bcnt_clr = 1'b0;
        bcnt_sel = 2'd1;
`endif
        #1 rst = 1'b1;
        step(2);

        // Reset values for both reset polarities.
        chk("rst_clean0", 32'(clean0), 32'h0);
        chk("rst_rise0", 32'(rise0), 32'h0);
        chk("rst_fall0", 32'(fall0), 32'h0);
        chk("rst_any0", 32'(any0), 32'h0);
        chk("rst_clean1", 32'(clean1), 32'hF);
        chk("rst_pulses1", 32'({rise1, fall1, any1}), 32'h0);
        rst = 1'b0;

        // No activity after release with inputs at the reset level.
        for (int k = 0; k < 10; k++) begin
            step(1);
            chk("idle_clean1", 32'(clean1), 32'hF);
            chk("idle_pulses1", 32'({rise1, fall1, any1}), 32'h0);
            chk("idle_pulses0", 32'({clean0, rise0, fall0, any0}), 32'h0);
        end

        // Single rise on ch0: visible exactly at edge 7.
        bin0 = 4'b0001;
        for (int e = 1; e <= 6; e++) begin
            step(1);
            chk("rise_wait_clean", 32'(clean0), 32'h0);
            chk("rise_wait_pulse", 32'({rise0, any0}), 32'h0);
        end
        step(1);
        chk("rise_clean", 32'(clean0), 32'h1);
        chk("rise_pulse", 32'(rise0), 32'h1);
        chk("rise_any", 32'(any0), 32'h1);
        chk("rise_fall", 32'(fall0), 32'h0);
        step(1);
        chk("rise_after_pulse", 32'({rise0, fall0, any0}), 32'h0);
        chk("rise_after_clean", 32'(clean0), 32'h1);

        // ch1 toggles every 2 cycles, then settles high.
        for (int k = 0; k < 10; k++) begin
            bin0[1] = ~bin0[1];
            step(2);
            chk("bounce_clean", 32'(clean0), 32'h1);
            chk("bounce_pulse", 32'({rise0, fall0, any0}), 32'h0);
        end
        bin0[1] = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            step(1);
            chk("bounce_wait", 32'(clean0), 32'h1);
        end
        step(1);
        chk("bounce_clean_final", 32'(clean0), 32'h3);
        chk("bounce_rise", 32'(rise0), 32'h2);
        step(1);
        chk("bounce_single_rise", 32'({rise0, fall0, any0}), 32'h0);

        // 3-cycle glitch on ch2 never reaches the output.
        bin0[2] = 1'b1;
        step(3);
        bin0[2] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step(1);
            chk("glitch_clean", 32'(clean0), 32'h3);
            chk("glitch_pulse", 32'({rise0, fall0, any0}), 32'h0);
        end

        // Simultaneous rise on ch0 and fall on ch3.
        bin0 = 4'b1010;
        step(8);
        chk("simul_setup", 32'(clean0), 32'hA);
        bin0 = 4'b0011;
        for (int e = 1; e <= 6; e++) begin
            step(1);
            chk("simul_wait", 32'(clean0), 32'hA);
        end
        step(1);
        chk("simul_rise", 32'(rise0), 32'h1);
        chk("simul_fall", 32'(fall0), 32'h8);
        chk("simul_any", 32'(any0), 32'h1);
        chk("simul_clean", 32'(clean0), 32'h3);

        // Reset in the middle of a count discards the progress.
        bin0 = 4'b0111;
        step(5);
        chk("midrst_before", 32'(clean0), 32'h3);
        rst = 1'b1;
        #1;
        chk("midrst_clean", 32'(clean0), 32'h0);
        chk("midrst_pulse", 32'({rise0, fall0, any0}), 32'h0);
        step(2);
        rst = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            step(1);
            chk("postrst_clean", 32'(clean0), 32'h0);
            chk("postrst_pulse", 32'({rise0, fall0, any0}), 32'h0);
        end
        step(1);
        chk("postrst_clean_final", 32'(clean0), 32'h7);
        chk("postrst_rise", 32'(rise0), 32'h7);
        chk("postrst_any", 32'(any0), 32'h1);
        chk("dut1_final", 32'({clean1, rise1, fall1}), 32'hF00);

`ifdef DEBOUNCE_BOUNCE_COUNT_EN
        // Bounce counter saturation, clear priority and channel select.
        bcnt_sel = 2'd1;
        for (int k = 0; k < 300; k++) begin
            bin0[1] = ~bin0[1];
            step(1);
        end
        step(3);
        chk("bcnt_sat", 32'(bcnt_out0), 32'd255);
        for (int k = 0; k < 6; k++) begin
            bin0[1] = ~bin0[1];
            if (k == 3) bcnt_clr = 1'b1;
            step(1);
            if (k == 3) begin
                bcnt_clr = 1'b0;
                chk("bcnt_clr", 32'(bcnt_out0), 32'd0);
            end
        end
        bcnt_sel = 2'd2;
        #1;
        chk("bcnt_sel2", 32'(bcnt_out0), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
